// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_arb_pkg
//  Purpose  : Shared types and parameter limits for the async-FIFO write-port
//             round-robin arbiter (fifo_wr_arbiter, rr_pick).
//  Contents : arb_state_e - arbiter state encoding (idle / burst)
//             c_* limits  - legal ranges for NREQ and BURST
//  Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

    // Arbiter states: S_IDLE picks the next owner, S_BURST streams its words.
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } arb_state_e;

    // Legal parameter ranges.
    localparam int c_NREQ_MIN  = 2;
    localparam int c_NREQ_MAX  = 8;
    localparam int c_BURST_MIN = 1;
    localparam int c_BURST_MAX = 16;

endpackage : fifo_arb_pkg
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational round-robin picker. Scans the request vector
//             starting at (i_last + 1) mod NREQ and returns the first set bit.
//  Ports    : i_req   [NREQ]  request vector
//             i_last  [IW]    index of the previous owner
//             o_pick  [NREQ]  one-hot winner (all-zero when nothing requests)
//             o_found         high when o_pick is non-zero
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_last,
    output logic [NREQ-1:0] o_pick,
    output logic            o_found
);

    logic [IW-1:0] w_idx;

    // Offsets 1..NREQ visit every index exactly once, ending on i_last itself,
    // so the previous owner has the lowest priority.
    always_comb begin
        o_pick  = '0;
        o_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = IW'((int'(i_last) + k) % NREQ);
            if (!o_found && i_req[w_idx]) begin
                o_pick[w_idx] = 1'b1;
                o_found       = 1'b1;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Round-robin arbiter that merges NREQ valid/ready word streams
//             into the write port of an async FIFO, granting up to BURST
//             words per owner.
//  Ports    : wclk, wrst             FIFO write clock, async active-high reset
//             req_valid/req_data     per-requester word streams
//             req_ready              per-requester accept
//             wfull                  FIFO full (wclk domain, registered)
//             winc/wdata             FIFO write strobe and data
//             grant                  one-hot current owner (0 when idle)
//             busy                   high while a burst is in progress
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic [NREQ-1:0]       grant,
    output logic                  busy
);

    localparam int c_IDX_W = $clog2(NREQ);
    localparam int c_CNT_W = $clog2(BURST) + 1;

    if ((NREQ < c_NREQ_MIN) || (NREQ > c_NREQ_MAX) ||
        (BURST < c_BURST_MIN) || (BURST > c_BURST_MAX)) begin : g_param_check
        $error("fifo_wr_arbiter: NREQ or BURST outside legal range");
    end

    // ------------------------------------------------------------------
    // Registers and next-state values
    // ------------------------------------------------------------------
    arb_state_e          r_state_q, w_state_d;
    logic [NREQ-1:0]     r_grant_q, w_grant_d;
    logic [c_IDX_W-1:0]  r_gidx_q,  w_gidx_d;
    logic [c_CNT_W-1:0]  r_cnt_q,   w_cnt_d;
    logic [c_IDX_W-1:0]  r_last_q,  w_last_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NREQ-1:0]     w_pick;
    logic                w_found;
    logic [c_IDX_W-1:0]  w_pick_idx;
    logic [DSIZE-1:0]    w_words [NREQ];
    logic                w_gvalid;
    logic                w_xfer;
    logic [c_CNT_W-1:0]  w_cnt_inc;

    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign w_words[i] = req_data[i*DSIZE +: DSIZE];
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (c_IDX_W)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_last  (r_last_q),
        .o_pick  (w_pick),
        .o_found (w_found)
    );

    // Index of the one-hot pick, registered alongside the one-hot grant so
    // the datapath mux needs no encoder on the burst path.
    always_comb begin
        w_pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_pick[i]) begin
                w_pick_idx = c_IDX_W'(i);
            end
        end
    end

    assign w_gvalid  = req_valid[r_gidx_q];
    // A word moves only in a burst, with the owner valid and the FIFO not full.
    assign w_xfer    = (r_state_q == S_BURST) && w_gvalid && !wfull;
    assign w_cnt_inc = r_cnt_q + c_CNT_W'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state_q <= S_IDLE;
            r_grant_q <= '0;
            r_gidx_q  <= '0;
            r_cnt_q   <= '0;
            r_last_q  <= c_IDX_W'(NREQ - 1);
        end else begin
            r_state_q <= w_state_d;
            r_grant_q <= w_grant_d;
            r_gidx_q  <= w_gidx_d;
            r_cnt_q   <= w_cnt_d;
            r_last_q  <= w_last_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_grant_d = r_grant_q;
        w_gidx_d  = r_gidx_q;
        w_cnt_d   = r_cnt_q;
        w_last_d  = r_last_q;
        case (r_state_q)
            S_IDLE: begin
                if (w_found) begin
                    w_state_d = S_BURST;
                    w_grant_d = w_pick;
                    w_gidx_d  = w_pick_idx;
                    w_cnt_d   = '0;
                end
            end
            S_BURST: begin
                // A dropped valid ends the burst even while the FIFO is full;
                // a full FIFO otherwise freezes everything.
                if (!w_gvalid) begin
                    w_state_d = S_IDLE;
                    w_grant_d = '0;
                    w_cnt_d   = '0;
                    w_last_d  = r_gidx_q;
                end else if (w_xfer) begin
                    w_cnt_d = w_cnt_inc;
                    if (w_cnt_inc == c_CNT_W'(BURST)) begin
                        w_state_d = S_IDLE;
                        w_grant_d = '0;
                        w_cnt_d   = '0;
                        w_last_d  = r_gidx_q;
                    end
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_grant_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (no register stage: wfull must gate winc directly)
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        req_ready = '0;
        winc      = 1'b0;
        wdata     = '0;
        if (r_state_q == S_BURST) begin
            busy  = 1'b1;
            winc  = w_xfer;
            wdata = w_words[r_gidx_q];
            if (!wfull) begin
                req_ready = r_grant_q;
            end
        end
    end

    assign grant = r_grant_q;

endmodule : fifo_wr_arbiter
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter (DSIZE=8, NREQ=4,
//             BURST=4). Requesters are queue-backed sources; each loaded word
//             is also pushed, in expected write order, onto a scoreboard that
//             is popped on every winc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int DSIZE = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic                  wclk = 1'b0;
    logic                  wrst;
    logic                  wfull;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*DSIZE-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  winc;
    logic [DSIZE-1:0]      wdata;
    logic [NREQ-1:0]       grant;
    logic                  busy;

    fifo_wr_arbiter #(
        .DSIZE (DSIZE),
        .NREQ  (NREQ),
        .BURST (BURST)
    ) u_dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        int               idx;
        logic [DSIZE-1:0] data;
    } exp_t;

    exp_t             exp_q [$];
    logic [DSIZE-1:0] src_q [NREQ][$];
    int               seq   [NREQ];
    int               n_cmp  = 0;
    int               n_err  = 0;
    int               n_winc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Queue n words on requester i and record them as the next expected writes.
    task automatic load(input int i, input int n);
        exp_t e;
        logic [DSIZE-1:0] d;
        for (int k = 0; k < n; k++) begin
            d = DSIZE'((i << 4) | (seq[i] & 15));
            seq[i]++;
            src_q[i].push_back(d);
            e.idx  = i;
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    function automatic bit all_empty();
        bit r;
        r = (exp_q.size() == 0);
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    // Wait until every source and the scoreboard are drained; returns cycles.
    task automatic wait_drain(input string tag, output int cyc);
        cyc = 0;
        while (!all_empty() && cyc < 300) begin
            @(posedge wclk);
            #2;
            cyc++;
        end
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Source driver and output monitor.
    initial begin : p_driver
        logic [NREQ-1:0] xfer;
        exp_t            e;
        req_valid = '0;
        req_data  = '0;
        forever begin
            @(negedge wclk);
            xfer = req_valid & req_ready;
            if (!wrst) begin
                chk("winc_vs_handshake", 32'(winc), 32'(|xfer));
                chk("winc_while_full", 32'(winc & wfull), 32'd0);
                chk("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
                if (winc) begin
                    n_winc++;
                    if (exp_q.size() == 0) begin
                        chk("winc_with_empty_scoreboard", 32'(winc), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wdata", 32'(wdata), 32'(e.data));
                        chk("grant", 32'(grant), 32'(1) << e.idx);
                    end
                end
            end
            @(posedge wclk);
            for (int i = 0; i < NREQ; i++) begin
                if (xfer[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            end
            #1;
            for (int i = 0; i < NREQ; i++) begin
                req_valid[i] = (src_q[i].size() > 0);
                req_data[i*DSIZE +: DSIZE] = (src_q[i].size() > 0) ? src_q[i][0]
                                                                     : DSIZE'($urandom);
            end
        end
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : p_main
        int cyc;
        int base;
        for (int i = 0; i < NREQ; i++) seq[i] = 0;
        wrst  = 1'b1;
        wfull = 1'b0;
        repeat (3) @(posedge wclk);
        #2;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_wdata", 32'(wdata), 32'd0);
        @(posedge wclk);
        #2;
        wrst = 1'b0;

        // All four valid: grants 0,1,2,3,0 with 4 words each, one pick cycle
        // between bursts (1 cycle driver latency + 5 x (pick + 4 words)).
        base = n_winc;
        load(0, 4); load(1, 4); load(2, 4); load(3, 4); load(0, 4);
        wait_drain("rr", cyc);
        chk("rr_cycles", 32'(cyc), 32'd26);
        chk("rr_wincs", 32'(n_winc - base), 32'd20);
        chk("rr_idle_busy", 32'(busy), 32'd0);

        // Only requester 2, three words then valid drops.
        base = n_winc;
        load(2, 3);
        wait_drain("short", cyc);
        chk("short_cycles", 32'(cyc), 32'd5);
        @(posedge wclk);
        #2;
        chk("short_busy", 32'(busy), 32'd0);
        chk("short_grant", 32'(grant), 32'd0);
        chk("short_wincs", 32'(n_winc - base), 32'd3);
        load(2, 1);
        wait_drain("regrant2", cyc);
        // last owner is 2, so 3 must precede 1.
        load(3, 1); load(1, 1);
        wait_drain("after2", cyc);

        // wfull for 5 cycles after 2 words of a burst from requester 0,
        // with requester 3 becoming valid during the stall.
        load(0, 4);
        repeat (4) @(posedge wclk);
        #1;
        wfull = 1'b1;
        load(3, 2);
        repeat (5) begin
            @(negedge wclk);
            chk("full_grant", 32'(grant), 32'd1);
            chk("full_winc", 32'(winc), 32'd0);
            chk("full_ready", 32'(req_ready), 32'd0);
        end
        @(posedge wclk);
        #1;
        wfull = 1'b0;
        wait_drain("full", cyc);

        // Reset in the middle of a burst from requester 1 (last owner 0).
        load(0, 1);
        wait_drain("pre_rst", cyc);
        @(posedge wclk);
        #2;
        load(1, 4);
        repeat (3) @(posedge wclk);
        #2;
        wrst = 1'b1;
        #1;
        chk("arst_grant", 32'(grant), 32'd0);
        chk("arst_winc", 32'(winc), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        exp_q.delete();
        @(posedge wclk);
        @(posedge wclk);
        #2;
        wrst = 1'b0;
        // After reset requester 0 wins over requester 1.
        load(0, 1); load(1, 1);
        wait_drain("post_rst", cyc);

        repeat (3) @(posedge wclk);
        #2;
        chk("final_scoreboard", 32'(exp_q.size()), 32'd0);
        chk("final_busy", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo_wr_arbiter
`default_nettype wire
